// File: rtl/serial_word_feeder.sv
// Parallel-to-serial feeder: captures a word, pulses clr_next, then shifts it out LSB-first.
// Latency: clr_next one cycle after acceptance, bit 0 two cycles after, one bit per cycle.
// Backpressure: load_ready only in IDLE or on the last bit cycle; upstream holds the word otherwise.
module serial_word_feeder #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             clr_next,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_first,
  output logic             ser_last,
  output logic             busy,
  output logic [CNT_W-1:0] word_cnt
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CLR   = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;

  logic [1:0]       state, state_nx;
  logic [WIDTH-1:0] shreg, shreg_nx;
  logic [IDX_W-1:0] idx, idx_nx;
  logic             at_last;
  logic             take;

  // The last bit cycle doubles as an acceptance slot so back-to-back words cost only one bubble.
  assign at_last    = (state == SHIFT) && (idx == LAST_IDX);
  assign load_ready = (state == IDLE) || at_last;
  assign take       = load_valid && load_ready;

  // Next-state, shift register and bit index; outputs below are registered from these.
  always_comb begin
    state_nx = state;
    shreg_nx = shreg;
    idx_nx   = idx;
    case (state)
      IDLE: begin
        if (take) begin
          shreg_nx = load_data;
          state_nx = CLR;
        end
      end
      CLR: begin
        idx_nx   = '0;
        state_nx = SHIFT;
      end
      SHIFT: begin
        shreg_nx = shreg >> 1;
        idx_nx   = idx + IDX_W'(1);
        if (at_last) begin
          idx_nx = '0;
          if (take) begin
            shreg_nx = load_data;
            state_nx = CLR;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: begin
        state_nx = IDLE;
        idx_nx   = '0;
      end
    endcase
  end

  // State, datapath and registered outputs; reset aborts any word in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      shreg     <= '0;
      idx       <= '0;
      word_cnt  <= '0;
      clr_next  <= 1'b0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      ser_first <= 1'b0;
      ser_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      shreg     <= shreg_nx;
      idx       <= idx_nx;
      if (at_last) begin
        word_cnt <= word_cnt + CNT_W'(1);
      end
      clr_next  <= (state_nx == CLR);
      ser_valid <= (state_nx == SHIFT);
      ser_out   <= (state_nx == SHIFT) && shreg_nx[0];
      ser_first <= (state_nx == SHIFT) && (idx_nx == '0);
      ser_last  <= (state_nx == SHIFT) && (idx_nx == LAST_IDX);
      busy      <= (state_nx != IDLE);
    end
  end

endmodule

// File: tb/tb_serial_word_feeder.sv
// Bench for serial_word_feeder (WIDTH=4): per-cycle expected outputs queued at acceptance.
// A second instance with CNT_W=2 shares all inputs to exercise counter wrap.
// Inputs driven 1ns after the rising edge, outputs checked on the falling edge.
module tb_serial_word_feeder;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         load_valid;
  logic [W-1:0] load_data;
  logic         load_ready, clr_next, ser_out, ser_valid, ser_first, ser_last, busy;
  logic [7:0]   word_cnt;
  logic         load_ready2, clr_next2, ser_out2, ser_valid2, ser_first2, ser_last2, busy2;
  logic [1:0]   word_cnt2;

  serial_word_feeder #(.WIDTH(W), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .clr_next(clr_next), .ser_out(ser_out), .ser_valid(ser_valid),
    .ser_first(ser_first), .ser_last(ser_last), .busy(busy), .word_cnt(word_cnt)
  );

  serial_word_feeder #(.WIDTH(W), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready2), .clr_next(clr_next2), .ser_out(ser_out2), .ser_valid(ser_valid2),
    .ser_first(ser_first2), .ser_last(ser_last2), .busy(busy2), .word_cnt(word_cnt2)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic clr;
    logic vld;
    logic dbit;
    logic first;
    logic last;
  } ent_t;

  ent_t   sbq[$];
  ent_t   cur, nxt;
  logic   exp_rdy;
  logic [7:0] exp_cnt = '0;
  logic   chk_en = 1'b0;
  int     n_cmp = 0;
  int     n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Per-cycle scoreboard: pop this cycle's expectation, compare, then queue the next word if accepted.
  always @(negedge clk) begin
    if (chk_en) begin
      cur = (sbq.size() > 0) ? sbq.pop_front() : ent_t'(0);
      exp_rdy = !(cur.clr || cur.vld) || cur.last;
      check_val("clr_next",   32'(clr_next),   32'(cur.clr));
      check_val("ser_valid",  32'(ser_valid),  32'(cur.vld));
      check_val("busy",       32'(busy),       32'(cur.clr | cur.vld));
      check_val("load_ready", 32'(load_ready), 32'(exp_rdy));
      check_val("word_cnt",   32'(word_cnt),   32'(exp_cnt));
      check_val("word_cnt2",  32'(word_cnt2),  32'(exp_cnt[1:0]));
      if (cur.vld) begin
        check_val("ser_out",   32'(ser_out),   32'(cur.dbit));
        check_val("ser_first", 32'(ser_first), 32'(cur.first));
        check_val("ser_last",  32'(ser_last),  32'(cur.last));
      end
      if (reset) begin
        sbq.delete();
        exp_cnt = '0;
      end else begin
        if (cur.last) exp_cnt = exp_cnt + 8'd1;
        if (load_valid && exp_rdy) begin
          nxt = '0;
          nxt.clr = 1'b1;
          sbq.push_back(nxt);
          for (int i = 0; i < W; i++) begin
            nxt = '0;
            nxt.vld   = 1'b1;
            nxt.dbit  = load_data[i];
            nxt.first = (i == 0);
            nxt.last  = (i == W - 1);
            sbq.push_back(nxt);
          end
        end
      end
    end
  end

  // Present a word and hold it until accepted; optionally keep load_valid high afterwards.
  task automatic send(input logic [W-1:0] word, input bit keep);
    int n;
    load_valid = 1'b1;
    load_data  = word;
    n = 0;
    @(negedge clk);
    while (!load_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) check_val("accept_timeout", 32'(n), 32'(0));
    @(posedge clk); #1;
    if (!keep) load_valid = 1'b0;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    reset      = 1'b1;
    load_valid = 1'b1;
    load_data  = 4'b1111;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    reset      = 1'b0;
    load_valid = 1'b0;
    idle(2);

    // Single word
    send(4'b0110, 1'b0);
    idle(W + 3);

    // Back-to-back with load_valid held high
    send(4'b0001, 1'b1);
    send(4'b1000, 1'b0);
    idle(W + 3);

    // Reset on the second shift cycle aborts the word
    send(4'b1011, 1'b0);
    idle(2);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    idle(3);

    // New data and toggling valid while busy must be ignored
    send(4'b1101, 1'b0);
    for (int i = 0; i < W; i++) begin
      load_valid = ~load_valid;
      load_data  = W'($urandom);
      idle(1);
    end
    load_valid = 1'b0;
    idle(3);

    // Reset coinciding with load_valid: word not taken
    reset      = 1'b1;
    load_valid = 1'b1;
    load_data  = 4'b0101;
    idle(1);
    reset      = 1'b0;
    load_valid = 1'b0;
    idle(2);

    // Random words, mixing back-to-back and gaps; also drives the 2-bit counter through wrap
    for (int k = 0; k < 8; k++) begin
      send(W'($urandom), ($urandom_range(0, 1) == 1));
      if (!load_valid) idle($urandom_range(0, 2));
    end
    load_valid = 1'b0;
    idle(W + 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
